// File: rtl/approx_mul_seq.sv
// Iterative shift-add unsigned multiplier with a per-operation exact/approximate select.
// Approximate mode drops partial-product columns [TRUNC_COLS-1:0] before accumulation.
`timescale 1ns/1ps
module approx_mul_seq #(
   parameter int WIDTH      = 9,
   parameter int TRUNC_COLS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_approx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic                 out_approx
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [PW-1:0] TRUNC_MASK = {PW{1'b1}} << TRUNC_COLS;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   a_sh;
   logic [WIDTH-1:0] b_sh;
   logic            approx_reg;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   addend;
   logic [PW-1:0]   col_mask;
   logic [CW-1:0]   cnt;
   logic            last_step;

   // BUSY spends one extra cycle after the final add so DONE lands WIDTH+1 edges after accept.
   assign last_step = (cnt == CW'(WIDTH));
   assign col_mask  = approx_reg ? TRUNC_MASK : '1;
   assign addend    = b_sh[0] ? (a_sh & col_mask) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         approx_reg <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh       <= PW'(in_a);
                  b_sh       <= in_b;
                  approx_reg <= in_approx;
                  acc        <= '0;
                  cnt        <= '0;
               end
            end
            BUSY: begin
               if (!last_step) begin
                  acc  <= acc + addend;
                  a_sh <= a_sh << 1;
                  b_sh <= b_sh >> 1;
                  cnt  <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_p      = acc;
   assign out_approx = approx_reg;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Bench for approx_mul_seq: directed vector table, backpressure and mid-op reset
// sequences, then randomized valid/ready traffic checked through a result scoreboard.
`timescale 1ns/1ps
module tb_approx_mul_seq;

   localparam int W  = 9;
   localparam int TC = 4;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_approx;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_p;
   logic          out_approx;

   approx_mul_seq #(.WIDTH(W), .TRUNC_COLS(TC)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_approx  (in_approx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_approx (out_approx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          ap;
      logic [PW-1:0] p;
   } rec_t;

   rec_t          sb[$];
   rec_t          tbl[11];
   rec_t          e;
   int            tests = 0;
   int            fails = 0;
   logic          hold_prev = 1'b0;
   logic [PW-1:0] prev_p;
   logic          prev_ap;
   logic [PW-1:0] exact;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ap);
      logic [PW-1:0] r = '0;
      logic [PW-1:0] mask;
      mask = ap ? ~((PW'(1) << TC) - PW'(1)) : '1;
      for (int i = 0; i < W; i++) begin
         if (b[i]) r += (PW'(a) << i) & mask;
      end
      return r;
   endfunction

   // Scoreboard: push at the accept edge, pop at the transfer edge, watch held outputs.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_p", 64'(out_p), 64'(prev_p));
            chk("hold_approx", 64'(out_approx), 64'(prev_ap));
         end
         if (in_valid && in_ready)
            sb.push_back('{a: in_a, b: in_b, ap: in_approx, p: ref_mul(in_a, in_b, in_approx)});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_p", 64'(out_p), 64'(e.p));
               chk("sb_approx", 64'(out_approx), 64'(e.ap));
               if (e.ap) begin
                  exact = PW'(e.a) * PW'(e.b);
                  chk("low_cols_zero", 64'(out_p[TC-1:0]), 64'd0);
                  chk("err_not_above", 64'(out_p <= exact), 64'd1);
                  chk("err_bound", 64'((exact - out_p) < PW'(W * (1 << TC))), 64'd1);
               end
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_p    = out_p;
         prev_ap   = out_approx;
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                         input logic rdy, output logic [PW-1:0] p, output logic pa,
                         output int lat);
      int guard;
      @(posedge clk); #1;
      in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1; out_ready = rdy;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_approx = ~ap;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 100) chk("result_timeout", 64'd0, 64'd1);
      p  = out_p;
      pa = out_approx;
   endtask

   logic [PW-1:0] got_p;
   logic          got_ap;
   int            lat;
   int            n_acc;
   int            cyc;
   int            guard;
   logic          acc_now;

   initial begin
      tbl[0]  = '{9'd511, 9'd511, 1'b0, 18'd261121};
      tbl[1]  = '{9'd511, 9'd511, 1'b1, 18'd261072};
      tbl[2]  = '{9'd1,   9'd1,   1'b1, 18'd0};
      tbl[3]  = '{9'd0,   9'd300, 1'b0, 18'd0};
      tbl[4]  = '{9'd300, 9'd0,   1'b0, 18'd0};
      tbl[5]  = '{9'd3,   9'd5,   1'b0, 18'd15};
      tbl[6]  = '{9'd3,   9'd5,   1'b1, 18'd0};
      tbl[7]  = '{9'd100, 9'd200, 1'b1, 18'd20000};
      tbl[8]  = '{9'd17,  9'd1,   1'b1, 18'd16};
      tbl[9]  = '{9'd255, 9'd3,   1'b1, 18'd736};
      tbl[10] = '{9'd511, 9'd256, 1'b1, 18'd130816};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_approx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_p", 64'(out_p), 64'd0);
      chk("rst_out_approx", 64'(out_approx), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].ap, 1'b1, got_p, got_ap, lat);
         chk("vec_p", 64'(got_p), 64'(tbl[i].p));
         chk("vec_approx", 64'(got_ap), 64'(tbl[i].ap));
         chk("vec_latency", 64'(lat), 64'(W + 1));
      end

      // Backpressure: result must sit in DONE with no new accept.
      run_op(9'd511, 9'd511, 1'b0, 1'b0, got_p, got_ap, lat);
      chk("bp_p", 64'(got_p), 64'd261121);
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_p", 64'(out_p), 64'd261121);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of BUSY.
      in_a = 9'd511; in_b = 9'd511; in_approx = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_p", 64'(out_p), 64'd0);
      chk("mid_rst_approx", 64'(out_approx), 64'd0);
      run_op(9'd3, 9'd5, 1'b0, 1'b1, got_p, got_ap, lat);
      chk("post_rst_p", 64'(got_p), 64'd15);

      // Random valid/ready traffic; the scoreboard does the checking.
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_acc = 0;
      cyc = 0;
      while (n_acc < 1500 && cyc < 60000) begin
         @(negedge clk);
         acc_now = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            in_valid = 1'b0;
            n_acc++;
         end
         if (!in_valid && $urandom_range(0, 2) == 0) in_valid = 1'b1;
         if (in_valid) begin
            case ($urandom_range(0, 7))
               0: in_a = '1;
               1: in_a = '0;
               default: in_a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
               0: in_b = '1;
               1: in_b = '0;
               default: in_b = W'($urandom);
            endcase
            in_approx = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      chk("random_ops_done", 64'(n_acc), 64'd1500);
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
